// File: rtl/param_arb_mux.sv
// param_arb_mux: N-channel, W-bit stream multiplexer with run-time fixed-select
// or round-robin arbitration feeding one registered valid/ready output stage.
module param_arb_mux #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0]  out_data_r;
  logic [SW-1:0] out_ch_r;
  logic          out_valid_r;
  logic [SW-1:0] ptr_r;
  logic [SW-1:0] ptr_next_s;
  logic [SW-1:0] grant_s;
  logic          grant_valid_s;
  logic          load_en_s;
  logic [N-1:0]  in_ready_s;

  // The output register may refill on the same edge it drains.
  assign load_en_s = ~out_valid_r | out_ready;

  // Grant selection; round-robin searches ptr..N-1 first, then wraps to 0..ptr-1.
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    if (mode == 1'b0) begin
      for (int k = 0; k < N; k++) begin
        if (!grant_valid_s && (int'(sel) == k) && in_valid[k]) begin
          grant_s       = SW'(k);
          grant_valid_s = 1'b1;
        end else begin
          grant_s = grant_s;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!grant_valid_s && (k >= int'(ptr_r)) && in_valid[k]) begin
          grant_s       = SW'(k);
          grant_valid_s = 1'b1;
        end else begin
          grant_s = grant_s;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!grant_valid_s && in_valid[k]) begin
          grant_s       = SW'(k);
          grant_valid_s = 1'b1;
        end else begin
          grant_s = grant_s;
        end
      end
    end
  end

  // One-hot ready towards the granted channel, suppressed while in reset.
  always_comb begin
    in_ready_s = '0;
    for (int k = 0; k < N; k++) begin
      in_ready_s[k] = rst_n & load_en_s & grant_valid_s & (int'(grant_s) == k);
    end
  end

  assign ptr_next_s = (int'(grant_s) == N - 1) ? '0 : grant_s + SW'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      ptr_r       <= '0;
    end else if (load_en_s) begin
      if (grant_valid_s) begin
        out_data_r  <= in_data[int'(grant_s)*W +: W];
        out_ch_r    <= grant_s;
        out_valid_r <= 1'b1;
        ptr_r       <= ptr_next_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/param_arb_mux.md
Name: param_arb_mux

Overview:
- Parametrised N-channel, W-bit stream multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Two selection modes, chosen at run time:
  - fixed-select: the channel is given by the sel input.
  - round-robin: a fair rotation over the channels that have data.
- Generalises the combinational N:1 bit mux into a sequential, back-pressure-aware data-path block that feeds a single downstream consumer.

Parameters:
- N, 8, number of input channels (N >= 2; need not be a power of two).
- W, 8, data width per channel in bits.
- SW (localparam), $clog2(N), width of the channel index.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit is high in any cycle.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SW  channel index used in fixed-select mode.
- out_data  output  W  registered output data.
- out_ch  output  SW  index of the channel that supplied out_data.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset:
  - While rst_n = 0, asynchronously force out_valid = 0, out_data = 0, out_ch = 0 and round-robin pointer ptr = 0.
  - in_ready is all-zero while in reset.
  - Any data held at reset is discarded.
- Load enable: load_en = ~out_valid | out_ready. The output register can accept new data in the same cycle it is drained, giving full throughput of 1 word per cycle.
- Grant (combinational):
  - mode = 0:
    - grant = sel when sel < N and in_valid[sel] = 1.
    - Otherwise there is no grant; this includes sel >= N for non-power-of-2 N.
  - mode = 1: grant = the first k with in_valid[k] = 1, searching ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N).
- in_ready[k] = load_en & grant_valid & (grant == k). A transfer on channel k is in_valid[k] & in_ready[k].
- On a clock edge with load_en = 1:
  - If a grant exists: out_data <= in_data[grant], out_ch <= grant, out_valid <= 1, and ptr <= (grant == N-1) ? 0 : grant+1.
  - If no grant exists: out_valid <= 0; out_data and out_ch hold their previous values.
- On a clock edge with load_en = 0: out_data, out_ch, out_valid and ptr all hold.
- Latency: 1 cycle from an input transfer to out_valid.
- ptr:
  - Updates on every grant in both modes, so switching to round-robin continues after the last served channel.
  - Wraps correctly for non-power-of-2 N; it never takes a value >= N.
- Output stability: once out_valid = 1, out_data and out_ch must not change until the cycle in which out_ready = 1.
- Mode or sel changes:
  - Take effect only at the next grant.
  - Never alter a word already held in the output register.
- Simultaneous events: input accept and output drain in the same cycle is legal. The old word leaves and the new word is loaded on the same edge.

Test Plan:
1. Reset: hold rst_n = 0 with all in_valid = 1 -> out_valid = 0, out_data = 0x00, out_ch = 0, in_ready = 8'h00. Release rst_n -> first transfer is on the next edge.
2. Fixed-select, N=8, W=8: mode = 0, sel = 3, ch3 = 0xA5 valid, ch1 = 0x11 valid, out_ready = 1 -> only in_ready[3] = 1. One cycle later out_data = 0xA5, out_ch = 3. ch1 is never accepted.
3. Round-robin: all 8 channels valid with data 0x10+k, out_ready = 1 -> out_ch = 0,1,…,7,0,1 on consecutive cycles, out_data = 0x10,…,0x17,0x10, with no idle cycles.
4. Backpressure:
   - Drop out_ready to 0 for 3 cycles while out_valid = 1 -> out_data and out_ch are stable and in_ready = 0.
   - Raise out_ready -> the held word drains, and the next grant loads on that same edge.
5. Non-power-of-2, N=5:
   - Round-robin with only ch4 and ch0 valid -> out_ch sequence 4,0,4,0 (the pointer wraps from 4 to 0).
   - Fixed-select with sel = 6 -> no in_ready is asserted and out_valid falls to 0 after the held word drains.
6. Reset mid-stream: after out_ch reaches 5 in round-robin, pulse rst_n low between clock edges -> out_valid drops immediately, without waiting for a clock. After release, the first grant goes to the lowest-index valid channel, because ptr = 0.
